// File: rtl/wb_stage_multi.sv
// wb_stage_multi: multi-lane writeback stage. Captures a bundle of register
// writes, drops x0/disabled lanes, and retires them oldest-lane-first through
// NUM_WR_PORTS registered write ports, back-pressuring while a bundle drains.
module wb_stage_multi #(
    parameter int N_BITS       = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int NUM_LANES    = 4,
    parameter int NUM_WR_PORTS = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_LANES-1:0]               in_we,
    input  logic [NUM_LANES*REG_ADDR_W-1:0]    in_rd,
    input  logic [NUM_LANES*N_BITS-1:0]        in_data,
    output logic [NUM_WR_PORTS-1:0]            wr_en,
    output logic [NUM_WR_PORTS*REG_ADDR_W-1:0] wr_addr,
    output logic [NUM_WR_PORTS*N_BITS-1:0]     wr_data,
    output logic                               busy
);
    localparam int CW = $clog2(NUM_LANES + 1);

    // Holding buffer (entries stay at their lane index) and output registers
    logic [NUM_LANES-1:0]                      pend_q, pend_d;
    logic [NUM_LANES-1:0][REG_ADDR_W-1:0]      rd_q, rd_d;
    logic [NUM_LANES-1:0][N_BITS-1:0]          data_q, data_d;
    logic [NUM_WR_PORTS-1:0]                   wr_en_q, wr_en_d;
    logic [NUM_WR_PORTS-1:0][REG_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [NUM_WR_PORTS-1:0][N_BITS-1:0]       wr_data_q, wr_data_d;

    logic [NUM_LANES-1:0][REG_ADDR_W-1:0]      in_rd_a;
    logic [NUM_LANES-1:0][N_BITS-1:0]          in_data_a;
    logic [NUM_LANES-1:0]                      live;
    logic [CW-1:0]                             pend_cnt;
    logic                                      buf_empty, accept;

    logic [NUM_LANES-1:0]                      src_pend;
    logic [NUM_LANES-1:0][REG_ADDR_W-1:0]      src_rd;
    logic [NUM_LANES-1:0][N_BITS-1:0]          src_data;
    logic [NUM_LANES-1:0][CW-1:0]              prefix;
    logic [NUM_LANES-1:0]                      taken;
    logic [NUM_WR_PORTS-1:0]                   sel_en, kill;
    logic [NUM_WR_PORTS-1:0][REG_ADDR_W-1:0]   sel_rd;
    logic [NUM_WR_PORTS-1:0][N_BITS-1:0]       sel_data;

    assign in_rd_a   = in_rd;
    assign in_data_a = in_data;

    // Live lanes: write-enabled and not targeting x0
    always_comb begin
        live = '0;
        for (int i = 0; i < NUM_LANES; i++)
            live[i] = in_we[i] & (in_rd_a[i] != '0);
    end

    // Pending count drives back-pressure: ready when the buffer empties this edge
    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++)
            pend_cnt = pend_cnt + CW'(pend_q[i]);
    end

    assign in_ready  = (pend_cnt <= CW'(NUM_WR_PORTS));
    assign buf_empty = ~|pend_q;
    assign accept    = in_valid & in_ready & ~flush;
    assign busy      = |pend_q;

    // Selection source: the buffer while draining, else the incoming bundle
    always_comb begin
        src_pend = buf_empty ? (accept ? live : '0) : pend_q;
        src_rd   = buf_empty ? in_rd_a   : rd_q;
        src_data = buf_empty ? in_data_a : data_q;
    end

    // Lowest-indexed pending entries go to ports 0.. in lane order
    always_comb begin
        prefix   = '0;
        taken    = '0;
        sel_en   = '0;
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 1; i < NUM_LANES; i++)
            prefix[i] = prefix[i-1] + CW'(src_pend[i-1]);
        for (int i = 0; i < NUM_LANES; i++)
            taken[i] = src_pend[i] & (prefix[i] < CW'(NUM_WR_PORTS));
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (src_pend[i] && prefix[i] == CW'(p)) begin
                    sel_en[p]   = 1'b1;
                    sel_rd[p]   = src_rd[i];
                    sel_data[p] = src_data[i];
                end
            end
        end
    end

    // Same-destination suppression: a later port with the same rd wins
    always_comb begin
        kill = '0;
        for (int j = 0; j < NUM_WR_PORTS; j++)
            for (int k = j + 1; k < NUM_WR_PORTS; k++)
                if (sel_en[j] && sel_en[k] && sel_rd[j] == sel_rd[k])
                    kill[j] = 1'b1;
    end

    // Next-state: retire, refill from an accepted bundle, or flush everything
    always_comb begin
        pend_d    = src_pend & ~taken;
        rd_d      = rd_q;
        data_d    = data_q;
        wr_en_d   = sel_en & ~kill;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (accept) begin
            rd_d   = in_rd_a;
            data_d = in_data_a;
            // Draining: pending entries all retire now, new bundle waits in full
            if (!buf_empty)
                pend_d = live;
        end
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            if (sel_en[p]) begin
                wr_addr_d[p] = sel_rd[p];
                wr_data_d[p] = sel_data[p];
            end
        end
        if (flush) begin
            pend_d    = '0;
            wr_en_d   = '0;
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= '0;
            rd_q      <= '0;
            data_q    <= '0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            pend_q    <= pend_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_wb_stage_multi.sv
// Scoreboard bench for wb_stage_multi: expected writes are queued when a
// bundle is accepted and popped as they appear on the write ports.
module tb_wb_stage_multi;
    localparam int NB = 32;
    localparam int RA = 5;
    localparam int NL = 4;
    localparam int NW = 2;

    typedef struct packed {
        logic [RA-1:0] a;
        logic [NB-1:0] d;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst, flush, in_valid, in_ready, busy;
    logic [NL-1:0]        in_we;
    logic [NL*RA-1:0]     in_rd;
    logic [NL*NB-1:0]     in_data;
    logic [NW-1:0]        wr_en;
    logic [NW*RA-1:0]     wr_addr;
    logic [NW*NB-1:0]     wr_data;

    exp_t                 sb[$];
    exp_t                 mon_e;
    logic [NB-1:0]        rf [32];
    int                   n_chk = 0;
    int                   n_pass = 0;

    wb_stage_multi #(.N_BITS(NB), .REG_ADDR_W(RA), .NUM_LANES(NL), .NUM_WR_PORTS(NW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_we(in_we), .in_rd(in_rd), .in_data(in_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Expected writes for a bundle: live lanes chunked per retire group,
    // lower duplicates inside a group dropped
    function automatic void push_bundle(input logic [NL-1:0] we, input logic [NL*RA-1:0] rd,
                                        input logic [NL*NB-1:0] d);
        exp_t lv[$];
        exp_t e;
        for (int i = 0; i < NL; i++) begin
            e.a = rd[i*RA +: RA];
            e.d = d[i*NB +: NB];
            if (we[i] && e.a != 0) lv.push_back(e);
        end
        for (int g = 0; g < lv.size(); g += NW) begin
            for (int j = g; j < g + NW && j < lv.size(); j++) begin
                bit dup = 0;
                for (int k = j + 1; k < g + NW && k < lv.size(); k++)
                    if (lv[k].a == lv[j].a) dup = 1;
                if (!dup) sb.push_back(lv[j]);
            end
        end
    endfunction

    // Monitor: every enabled port must match the next expected write
    always @(negedge clk) begin
        for (int p = 0; p < NW; p++) begin
            if (wr_en[p] === 1'b1) begin
                if (sb.size() == 0) chk("unexpected_wr", 64'(wr_addr[p*RA +: RA]), 64'hFFFF);
                else begin
                    mon_e = sb.pop_front();
                    chk("wr_addr", 64'(wr_addr[p*RA +: RA]), 64'(mon_e.a));
                    chk("wr_data", 64'(wr_data[p*NB +: NB]), 64'(mon_e.d));
                end
                rf[wr_addr[p*RA +: RA]] = wr_data[p*NB +: NB];
            end
        end
    end

    // Present a bundle, wait for acceptance, return just after the accepting edge
    task automatic send(input logic [NL-1:0] we, input logic [NL*RA-1:0] rd, input logic [NL*NB-1:0] d);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_we    = we;
        in_rd    = rd;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            push_bundle(we, rd, d);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Flush with a live bundle presented; it must be ignored
    task automatic do_flush();
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_we    = 4'hF;
        in_rd    = {5'd11, 5'd12, 5'd13, 5'd14};
        @(posedge clk);
        #1;
        sb.delete();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_wr_en", 64'(wr_en), 0);
        chk("flush_busy", 64'(busy), 0);
        chk("flush_ready", 64'(in_ready), 1);
    endtask

    function automatic logic [NL*RA-1:0] rds(input int a0, a1, a2, a3);
        return {RA'(a3), RA'(a2), RA'(a1), RA'(a0)};
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_we = '0; in_rd = '0; in_data = '0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_wr_en", 64'(wr_en), 0);
        chk("rst_wr_addr", 64'(wr_addr), 0);
        chk("rst_wr_data", 64'(wr_data), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_ready", 64'(in_ready), 1);

        // Full bundle: two pairs on consecutive cycles
        send(4'hF, rds(1, 2, 3, 4), {32'hD, 32'hC, 32'hB, 32'hA});
        chk("full_p1_en", 64'(wr_en), 2'b11);
        chk("full_p1_addr", 64'(wr_addr), {5'd2, 5'd1});
        chk("full_p1_busy", 64'(busy), 1);
        chk("full_p1_ready", 64'(in_ready), 1);
        idle();
        chk("full_p2_en", 64'(wr_en), 2'b11);
        chk("full_p2_addr", 64'(wr_addr), {5'd4, 5'd3});
        chk("full_p2_data", 64'(wr_data), {32'hD, 32'hC});
        chk("full_p2_busy", 64'(busy), 0);
        idle();
        chk("full_done_en", 64'(wr_en), 0);

        // x0 / write-enable filter
        send(4'b1011, rds(0, 5, 7, 9), {32'h99, 32'h77, 32'h55, 32'h00});
        chk("filt_en", 64'(wr_en), 2'b11);
        chk("filt_addr", 64'(wr_addr), {5'd9, 5'd5});
        chk("filt_busy", 64'(busy), 0);
        chk("filt_ready", 64'(in_ready), 1);
        idle();

        // Same destination in one retire group
        send(4'b0011, rds(6, 6, 0, 0), {32'h0, 32'h0, 32'h22, 32'h11});
        chk("samerd_en", 64'(wr_en), 2'b10);
        chk("samerd_data", 64'(wr_data[NB +: NB]), 32'h22);
        idle();
        @(negedge clk);
        chk("samerd_rf6", 64'(rf[6]), 32'h22);

        // Back-to-back bundles, in_valid held high
        send(4'hF, rds(1, 2, 3, 4), {32'h14, 32'h13, 32'h12, 32'h11});
        chk("b2b_a1_en", 64'(wr_en), 2'b11);
        send(4'hF, rds(8, 9, 10, 11), {32'h24, 32'h23, 32'h22, 32'h21});
        chk("b2b_a2_en", 64'(wr_en), 2'b11);
        chk("b2b_a2_addr", 64'(wr_addr), {5'd4, 5'd3});
        idle();
        chk("b2b_b1_en", 64'(wr_en), 2'b11);
        chk("b2b_b1_addr", 64'(wr_addr), {5'd9, 5'd8});
        idle();
        chk("b2b_b2_en", 64'(wr_en), 2'b11);
        chk("b2b_b2_addr", 64'(wr_addr), {5'd11, 5'd10});
        idle();

        // Flush after the first pair; next bundle accepted right after
        send(4'hF, rds(1, 2, 3, 4), {32'h34, 32'h33, 32'h32, 32'h31});
        chk("fl_busy", 64'(busy), 1);
        do_flush();
        send(4'b0011, rds(15, 16, 0, 0), {32'h0, 32'h0, 32'h46, 32'h45});
        chk("fl_next_en", 64'(wr_en), 2'b11);
        chk("fl_next_addr", 64'(wr_addr), {5'd16, 5'd15});
        idle();

        // Random traffic with gaps, duplicates, x0 and occasional flush
        for (int it = 0; it < 60; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) do_flush();
            else if (r < 3) idle();
            else send(4'($urandom), {RA'($urandom_range(0, 7)), RA'($urandom_range(0, 7)),
                                      RA'($urandom_range(0, 7)), RA'($urandom_range(0, 7))},
                      {$urandom, $urandom, $urandom, $urandom});
        end
        idle();
        for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
        chk("drain_empty", 64'(sb.size()), 0);

        // Reset mid-drain discards pending entries
        send(4'hF, rds(1, 2, 3, 4), {32'h54, 32'h53, 32'h52, 32'h51});
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rstmid_wr_en", 64'(wr_en), 0);
        chk("rstmid_busy", 64'(busy), 0);
        chk("rstmid_ready", 64'(in_ready), 1);
        chk("rstmid_addr", 64'(wr_addr), 0);
        idle();
        @(negedge clk);
        chk("rstmid_sb", 64'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
